// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default sizing, the grant-index width, the x0 register number
// and the round-robin pointer advance helper used by the top level.
package regfile_wb_arbiter_pkg;

  localparam int NREQ_DEF = 2;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int GID_W    = $clog2(NREQ_DEF);
  localparam int REG_ZERO = 0;

  // Pointer moves to the requester just after the winner, wrapping at n.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Rotate-priority picker: combinational.
// Scans valid starting at index ptr and wrapping modulo N; the first set bit wins.
// Ports:
//   valid  [N]  requests
//   ptr    [IW] index holding highest priority (must be < N)
//   onehot [N]  winner as a one-hot vector (zero when nothing is valid)
//   idx    [IW] winner index (zero when nothing is valid)
//   any    1    at least one request is valid
module regfile_wb_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && valid[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single regfile write port between NREQ requesters with
// round-robin priority and a valid/ready handshake, registers the winner
// into one output stage, and exports a bitmap of the register held there.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  [NREQ]       requester i presents a write
//   req_ready  [NREQ]       requester i accepted this cycle (one-hot or zero)
//   req_addr   [NREQ*AW]    destination of requester i at [i*AW +: AW]
//   req_data   [NREQ*XLEN]  data of requester i at [i*XLEN +: XLEN]
//   rf_stall   freeze: no grants, output stage holds
//   rf_we/rf_a3/rf_wd       registered regfile write port
//   grant_id   index of last accepted requester
//   pend_vec   [2**AW]      one-hot of the register being written, or zero
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*XLEN-1:0]     req_data,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_a3,
  output logic [XLEN-1:0]          rf_wd,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic [(2**AW)-1:0]       pend_vec
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0]   rr_ptr;
  logic [NREQ-1:0] win_onehot;
  logic [GW-1:0]   win_idx;
  logic            win_any;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  regfile_wb_arbiter_rr_pick #(
    .N  (NREQ),
    .IW (GW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  // Ready is gated by rst so nothing is acknowledged while reset is held.
  assign req_ready = (rst && !rf_stall) ? win_onehot : '0;

  assign win_addr = req_addr[win_idx*AW +: AW];
  assign win_data = req_data[win_idx*XLEN +: XLEN];

  // Output stage: accepted request lands here one cycle after the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (!rf_stall) begin
      if (win_any) begin
        rf_a3    <= win_addr;
        rf_wd    <= win_data;
        grant_id <= win_idx;
        rr_ptr   <= GW'(next_ptr(int'(win_idx), NREQ));
        // x0 writes complete the handshake but never reach the regfile.
        rf_we    <= (win_addr != AW'(REG_ZERO));
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  always_comb begin
    pend_vec = '0;
    if (rf_we) pend_vec[rf_a3] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=2, XLEN=32, AW=5).
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*AW-1:0]      req_addr = '0;
  logic [NREQ*XLEN-1:0]    req_data = '0;
  logic                    rf_stall = 1'b0;
  logic                    rf_we;
  logic [AW-1:0]           rf_a3;
  logic [XLEN-1:0]         rf_wd;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic [(2**AW)-1:0]      pend_vec;

  int total = 0;
  int bad   = 0;
  int gcyc;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .grant_id  (grant_id),
    .pend_vec  (pend_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_addr[i*AW +: AW]     = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state, including ready held low with a request pending.
    req_valid = 2'b01;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_a3", rf_a3, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_pend", pend_vec, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = 2'b00;
    tick();
    rst = 1'b1;

    // Single request to x5.
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 2'b01;
    #1;
    chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("single_we", rf_we, 1);
    chk("single_a3", rf_a3, 5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    chk("single_pend", pend_vec, 32'h20);
    chk("single_gid", grant_id, 0);
    tick();
    chk("single_we_off", rf_we, 0);
    chk("single_pend_off", pend_vec, 0);
    chk("single_a3_hold", rf_a3, 5);

    // Contention from reset: grants alternate 0,1,0,1.
    pulse_reset();
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hB1);
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("cont_ready", req_ready, (c % 2) ? 2'b10 : 2'b01);
      tick();
      chk("cont_gid", grant_id, c % 2);
      chk("cont_a3", rf_a3, (c % 2) ? 2 : 1);
      chk("cont_wd", rf_wd, (c % 2) ? 32'hB1 : 32'hA0);
    end
    req_valid = 2'b00;

    // x0 write: handshake completes, no regfile write.
    set_req(0, 5'd0, 32'h1234);
    req_valid = 2'b01;
    #1;
    chk("x0_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("x0_we", rf_we, 0);
    chk("x0_pend", pend_vec, 0);
    chk("x0_wd", rf_wd, 32'h1234);

    // Stall: accept x7, then freeze for 3 cycles with both requesters waiting.
    set_req(0, 5'd7, 32'h77);
    req_valid = 2'b01;
    #1;
    chk("stall_acc_ready", req_ready, 2'b01);
    tick();
    chk("stall_acc_a3", rf_a3, 7);
    set_req(0, 5'd9, 32'h99);
    set_req(1, 5'd3, 32'h33);
    req_valid = 2'b11;
    rf_stall  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", req_ready, 0);
      tick();
      chk("stall_we", rf_we, 1);
      chk("stall_a3", rf_a3, 7);
      chk("stall_pend", pend_vec, 32'h80);
    end
    rf_stall = 1'b0;
    #1;
    chk("unstall_ready", req_ready, 2'b10);
    tick();
    chk("unstall_gid", grant_id, 1);
    chk("unstall_a3", rf_a3, 3);
    chk("unstall_ready2", req_ready, 2'b01);
    tick();
    chk("unstall_a3b", rf_a3, 9);
    req_valid = 2'b10;
    set_req(1, 5'd4, 32'h44);
    #1;
    chk("pre_rst_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("pre_rst_we", rf_we, 1);
    chk("pre_rst_gid", grant_id, 1);

    // Asynchronous reset mid-cycle.
    #3;
    rst = 1'b0;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_pend", pend_vec, 0);
    chk("arst_gid", grant_id, 0);
    chk("arst_a3", rf_a3, 0);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("arst_first_ready", req_ready, 2'b01);
    tick();
    chk("arst_first_gid", grant_id, 0);
    req_valid = 2'b00;

    // Fairness: requester 0 always valid, requester 1 joins at cycle 10.
    pulse_reset();
    set_req(0, 5'd10, 32'h10);
    set_req(1, 5'd11, 32'h11);
    gcyc = -1;
    for (int c = 0; c < 16 && gcyc < 0; c++) begin
      req_valid = (c >= 10) ? 2'b11 : 2'b01;
      #1;
      if (req_ready[1]) gcyc = c;
      if (c == 5) chk("fair_early_ready", req_ready, 2'b01);
      tick();
    end
    chk("fair_granted", (gcyc >= 10 && gcyc <= 12) ? 1 : 0, 1);
    chk("fair_gid", grant_id, 1);
    req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
